// File: rtl/mux_rr_8to1.sv
// 8-to-1 round-robin merge with a single registered output slot.
// Channels present valid/ready handshakes; one channel is granted per free
// slot, searching upward from the channel after the last one granted.
module mux_rr_8to1 #(
    parameter int width = 8,
    parameter int snum  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [width-1:0]   i0,
    input  logic [width-1:0]   i1,
    input  logic [width-1:0]   i2,
    input  logic [width-1:0]   i3,
    input  logic [width-1:0]   i4,
    input  logic [width-1:0]   i5,
    input  logic [width-1:0]   i6,
    input  logic [width-1:0]   i7,
    input  logic [7:0]         i_valid,
    output logic [7:0]         i_ready,
    output logic [width-1:0]   o,
    output logic [snum-1:0]    sel,
    output logic               o_valid,
    input  logic               o_ready
);

    localparam int nch = 8;

    logic [nch*width-1:0] din_flat;
    logic [width-1:0]     din [nch];

    logic [width-1:0] o_reg;
    logic [2:0]       sel_reg;
    logic             o_valid_reg;
    logic [2:0]       ptr_reg;

    logic             slot_free;
    logic             grant_found;
    logic [2:0]       grant_idx;
    logic             take;

    assign din_flat = {i7, i6, i5, i4, i3, i2, i1, i0};

    // Unpack the channel inputs into an indexable array.
    generate
        for (genvar gi = 0; gi < nch; gi++) begin : g_din
            assign din[gi] = din_flat[gi*width +: width];
        end
    endgenerate

    // The slot can take a new word when empty or when its word leaves now.
    assign slot_free = !o_valid_reg || o_ready;

    // Round-robin search: ptr+1 .. ptr+8 (mod 8); the last candidate is ptr
    // itself so a lone requester that was just served is still granted.
    always_comb begin
        logic [2:0] cand;
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        cand        = 3'd0;
        for (int k = 1; k <= nch; k++) begin
            cand = ptr_reg + 3'(k);
            if (!grant_found && i_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // A grant happens only outside reset with a free slot and a requester.
    assign take = !rst && slot_free && grant_found;

    // One-hot ready on the granted channel; grant_idx is always a requester.
    generate
        for (genvar gi = 0; gi < nch; gi++) begin : g_ready
            assign i_ready[gi] = take && (grant_idx == 3'(gi));
        end
    endgenerate

    // Output slot and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_reg       <= '0;
            sel_reg     <= 3'd0;
            o_valid_reg <= 1'b0;
            ptr_reg     <= 3'd7;
        end else if (slot_free) begin
            if (grant_found) begin
                o_reg       <= din[grant_idx];
                sel_reg     <= grant_idx;
                o_valid_reg <= 1'b1;
                ptr_reg     <= grant_idx;
            end else begin
                o_valid_reg <= 1'b0;
            end
        end
    end

    assign o       = o_reg;
    assign sel     = snum'(sel_reg);
    assign o_valid = o_valid_reg;

endmodule
